// File: rtl/btn_event_classifier.sv
// ---------------------------------------------------------------------------
// btn_event_classifier
//
// Turns the clean level from the button debouncer into discrete UI events.
// Each press gesture is classified as a short press, a long press or a
// double click, reported as a single-cycle pulse. While a long press is still
// being held, `held` stays high as a level.
//
// Parameters
//   LONG_CYCLES : cycles a first press must stay high to count as long (>= 2)
//   GAP_CYCLES  : window after a first release in which a second press makes
//                 a double click (>= 2)
//   CNT_W       : internal counter width; both cycle counts must be
//                 <= 2**CNT_W
//
// Ports
//   clk          : system clock, rising edge
//   rst          : synchronous, active-high reset
//   btn_db       : debounced button level, 1 = pressed
//   short_press  : 1-cycle pulse, single short press with no follow-up press
//   long_press   : 1-cycle pulse, first press held for LONG_CYCLES
//   double_click : 1-cycle pulse, released second press of a double click
//   held         : level, high while a long press is still held
//   busy         : high whenever the classifier is not idle
// ---------------------------------------------------------------------------
module btn_event_classifier #(
  parameter int LONG_CYCLES = 1000,
  parameter int GAP_CYCLES  = 300,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_db,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic held,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESS1    = 3'd1,
    S_WAIT_GAP  = 3'd2,
    S_PRESS2    = 3'd3,
    S_LONG_HOLD = 3'd4
  } state_e;

  // Terminal counter values; both fit in CNT_W bits because each count is
  // bounded by 2**CNT_W.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_prev_q, btn_prev_d;

  logic short_press_q, short_press_d;
  logic long_press_q, long_press_d;
  logic double_click_q, double_click_d;
  logic held_q, held_d;
  logic busy_q, busy_d;

  logic rise;
  logic cnt_long_done;
  logic cnt_gap_done;

  // Edge detection against the previous sample. Only rising edges start
  // gestures; releases are detected from the level inside each state, so a
  // separate fall term is not needed.
  always_comb begin
    btn_prev_d    = btn_db;
    rise          = btn_db & ~btn_prev_q;
    cnt_long_done = (cnt_q == LONG_LAST);
    cnt_gap_done  = (cnt_q == GAP_LAST);
  end

  // -------------------------------------------------------------------------
  // State register. btn_prev resets to 1 so a button already held through
  // reset looks like a steady level, not a fresh press.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      btn_prev_q     <= 1'b1;
      short_press_q  <= 1'b0;
      long_press_q   <= 1'b0;
      double_click_q <= 1'b0;
      held_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      btn_prev_q     <= btn_prev_d;
      short_press_q  <= short_press_d;
      long_press_q   <= long_press_d;
      double_click_q <= double_click_d;
      held_q         <= held_d;
      busy_q         <= busy_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and counter logic. The counter restarts on every state entry,
  // so it never runs past a terminal value.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_PRESS1;
          cnt_d   = '0;
        end
      end

      S_PRESS1: begin
        if (!btn_db) begin
          state_d = S_WAIT_GAP;
          cnt_d   = '0;
        end else if (cnt_long_done) begin
          state_d = S_LONG_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_WAIT_GAP: begin
        // A second press landing on the expiry cycle still counts as a
        // double click.
        if (rise) begin
          state_d = S_PRESS2;
          cnt_d   = '0;
        end else if (cnt_gap_done) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_PRESS2: begin
        // Duration of the second press is irrelevant; only its release matters.
        if (!btn_db) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end

      S_LONG_HOLD: begin
        if (!btn_db) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode. Each pulse is tied to exactly one transition out of a
  // distinct state, which keeps the three events mutually exclusive and
  // limits every gesture to a single pulse.
  // -------------------------------------------------------------------------
  always_comb begin
    short_press_d  = 1'b0;
    long_press_d   = 1'b0;
    double_click_d = 1'b0;
    case (state_q)
      S_PRESS1:   long_press_d   = btn_db & cnt_long_done;
      S_WAIT_GAP: short_press_d  = ~rise & cnt_gap_done;
      S_PRESS2:   double_click_d = ~btn_db;
      default: begin
        short_press_d  = 1'b0;
        long_press_d   = 1'b0;
        double_click_d = 1'b0;
      end
    endcase
    // Levels follow the state being entered, so they line up with the pulses.
    held_d = (state_d == S_LONG_HOLD);
    busy_d = (state_d != S_IDLE);
  end

  assign short_press  = short_press_q;
  assign long_press   = long_press_q;
  assign double_click = double_click_q;
  assign held         = held_q;
  assign busy         = busy_q;

endmodule
